// File: rtl/output_stream_arbiter.sv
// Round-robin arbiter that shares one wide result stream among NB_REQ sources, holding each grant for a burst.
// Define OUTPUT_ARB_BURST_LOCK_EN to take the burst length from burst_len_i; otherwise every burst is one word.
module output_stream_arbiter #(
  parameter int NB_REQ = 4,
  parameter int BW     = 128,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      enable_i,
  input  logic [CNT_W-1:0]          burst_len_i,
  input  logic [NB_REQ-1:0]         req_valid_i,
  input  logic [NB_REQ*BW-1:0]      req_data_i,
  input  logic [NB_REQ*BW/8-1:0]    req_strb_i,
  output logic [NB_REQ-1:0]         req_ready_o,
  output logic                      out_valid_o,
  output logic [BW-1:0]             out_data_o,
  output logic [BW/8-1:0]           out_strb_o,
  input  logic                      out_ready_i,
  output logic [$clog2(NB_REQ)-1:0] out_src_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          words_sent_o
);
  localparam int SW    = BW / 8;
  localparam int IDX_W = $clog2(NB_REQ);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           r_state, w_state_n;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_n, r_gnt, w_gnt_n;
  logic [CNT_W-1:0] r_len, w_len_n, r_beat_cnt, w_beat_cnt_n, r_words_sent;
  logic [CNT_W-1:0] w_grant_len;
  logic [IDX_W-1:0] w_next_ptr, w_pick_idle, w_pick_next;
  logic             w_any_valid, w_hs, w_last_beat;
  logic [BW-1:0]    w_data [NB_REQ];
  logic [SW-1:0]    w_strb [NB_REQ];

  // First valid requester scanning upward from base, wrapping modulo NB_REQ.
  function automatic logic [IDX_W-1:0] f_pick(input logic [NB_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]  base);
    logic [IDX_W-1:0] res;
    logic             found;
    int               idx;
    res   = base;
    found = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = int'(base) + i;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        res   = IDX_W'(idx);
      end
    end
    return res;
  endfunction

  for (genvar r = 0; r < NB_REQ; r++) begin : g_unpack
    assign w_data[r] = req_data_i[r*BW +: BW];
    assign w_strb[r] = req_strb_i[r*SW +: SW];
  end

`ifdef OUTPUT_ARB_BURST_LOCK_EN
  assign w_grant_len = (burst_len_i == '0) ? CNT_W'(1) : burst_len_i;
`else
  logic w_unused_burst_len;
  assign w_unused_burst_len = ^burst_len_i;
  assign w_grant_len        = CNT_W'(1);
`endif

  assign w_any_valid = |req_valid_i;
  assign w_next_ptr  = (r_gnt == IDX_W'(NB_REQ - 1)) ? '0 : r_gnt + IDX_W'(1);
  assign w_pick_idle = f_pick(req_valid_i, r_rr_ptr);
  assign w_pick_next = f_pick(req_valid_i, w_next_ptr);
  // Clear suppresses the handshake so nothing is consumed in the clear cycle.
  assign w_hs        = (r_state == S_LOCKED) && req_valid_i[r_gnt] && out_ready_i && !clear_i;
  assign w_last_beat = (r_beat_cnt == r_len - CNT_W'(1));
  assign words_sent_o = r_words_sent;

  always_comb begin
    w_state_n    = r_state;
    w_rr_ptr_n   = r_rr_ptr;
    w_gnt_n      = r_gnt;
    w_len_n      = r_len;
    w_beat_cnt_n = r_beat_cnt;
    req_ready_o  = '0;
    out_valid_o  = 1'b0;
    out_data_o   = '0;
    out_strb_o   = '0;
    out_src_o    = '0;
    busy_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i && w_any_valid) begin
          w_state_n    = S_LOCKED;
          w_gnt_n      = w_pick_idle;
          w_len_n      = w_grant_len;
          w_beat_cnt_n = '0;
        end
      end
      S_LOCKED: begin
        busy_o      = 1'b1;
        out_src_o   = r_gnt;
        out_valid_o = req_valid_i[r_gnt] && !clear_i;
        if (out_valid_o) begin
          out_data_o = w_data[r_gnt];
          out_strb_o = w_strb[r_gnt];
        end
        req_ready_o[r_gnt] = out_ready_i && !clear_i;
        if (w_hs) begin
          if (w_last_beat) begin
            w_rr_ptr_n = w_next_ptr;
            // Re-grant on the same edge so back-to-back bursts have no bubble.
            if (enable_i && w_any_valid) begin
              w_gnt_n      = w_pick_next;
              w_len_n      = w_grant_len;
              w_beat_cnt_n = '0;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_beat_cnt_n = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_words_sent <= '0;
    end else if (clear_i) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_words_sent <= '0;
    end else begin
      r_state    <= w_state_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_gnt      <= w_gnt_n;
      r_len      <= w_len_n;
      r_beat_cnt <= w_beat_cnt_n;
      if (w_hs && (r_words_sent != '1)) r_words_sent <= r_words_sent + CNT_W'(1);
    end
  end
endmodule
